// File: rtl/single_port_ram.sv
// Single-port RAM, registered read address, write-first, self-clearing after reset.
// Optional parity storage/check enabled by defining SINGLE_PORT_RAM_PARITY_EN.
module single_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
`ifdef SINGLE_PORT_RAM_PARITY_EN
  input  logic                  err_inject,
  output logic                  parity_err,
`endif
  output logic [DATA_WIDTH-1:0] q,
  output logic                  busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SINGLE_PORT_RAM_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]      clrPtr_q, clrPtr_d;
  logic                  busy_q, busy_d;
  logic                  memWe;
  logic [IDX_W-1:0]      memIdx;
  logic [WORD_W-1:0]     memWdata;
  logic [WORD_W-1:0]     wrWord;
  logic [WORD_W-1:0]     rdWord;
  logic                  wrInRange;
  logic                  rdInRange;
  logic                  rdMasked;

  assign wrInRange = {1'b0, addr} < DEPTH_EXT;
  assign rdInRange = {1'b0, addr_q} < DEPTH_EXT;

`ifdef SINGLE_PORT_RAM_PARITY_EN
  assign wrWord = {(^data) ^ err_inject, data};
`else
  assign wrWord = data;
`endif

  // One shared write port: the clear sweep owns it while busy, user writes otherwise.
  always_comb begin
    addr_d   = addr;
    clrPtr_d = clrPtr_q;
    busy_d   = busy_q;
    memWe    = 1'b0;
    memIdx   = addr[IDX_W-1:0];
    memWdata = wrWord;
    if (rst) begin
      addr_d   = '0;
      clrPtr_d = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      memWe    = 1'b1;
      memIdx   = clrPtr_q;
      memWdata = '0;
      clrPtr_d = clrPtr_q + 1'b1;
      if (clrPtr_q == LAST_IDX) begin
        busy_d = 1'b0;
      end
    end else if (we && wrInRange) begin
      memWe = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    clrPtr_q <= clrPtr_d;
    busy_q   <= busy_d;
  end

  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memIdx] <= memWdata;
    end
  end

  // Reading through the registered address makes a same-edge write visible immediately.
  assign rdWord   = mem[addr_q[IDX_W-1:0]];
  assign rdMasked = busy_q || !rdInRange;
  assign q        = rdMasked ? '0 : rdWord[DATA_WIDTH-1:0];
  assign busy     = busy_q;

`ifdef SINGLE_PORT_RAM_PARITY_EN
  assign parity_err = rdMasked ? 1'b0 : ^rdWord;
`endif

endmodule

// File: tb/tb_single_port_ram.sv
// Randomised scoreboard bench for single_port_ram, with an abstract memory model.
// Out-of-range addresses are exercised by instantiating a wider address than DEPTH needs.
module tb_single_port_ram;
  localparam int DW    = 8;
  localparam int AW    = 7;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [DW-1:0] data;
  logic [AW-1:0] addr;
  logic [DW-1:0] q;
  logic          busy;
`ifdef SINGLE_PORT_RAM_PARITY_EN
  logic          errInject;
  logic          parityErr;
`endif

  always #5 clk = ~clk;

  single_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .addr(addr),
    .we(we),
`ifdef SINGLE_PORT_RAM_PARITY_EN
    .err_inject(errInject),
    .parity_err(parityErr),
`endif
    .q(q),
    .busy(busy)
  );

  typedef struct {
    int            cyc;
    int            a;
    logic [DW-1:0] expQ;
    logic          expBusy;
    logic          expPerr;
  } exp_t;

  exp_t sbQ[$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  // Reference model: contents, injected-parity flags, edges of clearing left, read address.
  int modelMem[DEPTH];
  bit modelInj[DEPTH];
  int busyLeft = 0;
  int addrReg  = 0;

  // Drive one edge's inputs, advance the model by one edge, queue the expected outputs.
  task automatic applyStimulus(input bit r, input bit w, input int a, input int d, input bit inj);
    exp_t e;
    @(negedge clk);
    rst  = r;
    we   = w;
    addr = AW'(a);
    data = DW'(d);
`ifdef SINGLE_PORT_RAM_PARITY_EN
    errInject = inj;
`endif
    if (r) begin
      busyLeft = DEPTH;
      addrReg  = 0;
    end else begin
      if (busyLeft > 0) begin
        busyLeft--;
        if (busyLeft == 0) begin
          for (int i = 0; i < DEPTH; i++) begin
            modelMem[i] = 0;
            modelInj[i] = 1'b0;
          end
        end
      end else if (w && a < DEPTH) begin
        modelMem[a] = d & 'hFF;
        modelInj[a] = inj;
      end
      addrReg = a;
    end
    e.cyc     = cycle;
    e.a       = addrReg;
    e.expBusy = (busyLeft > 0);
    if (busyLeft > 0 || addrReg >= DEPTH) begin
      e.expQ    = '0;
      e.expPerr = 1'b0;
    end else begin
      e.expQ    = DW'(modelMem[addrReg]);
      e.expPerr = modelInj[addrReg];
    end
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (busy !== e.expBusy) begin
      failures++;
      $display("[TB] FAIL busy cyc=%0d actual=%b required=%b", e.cyc, busy, e.expBusy);
    end
    checks++;
    if (q !== e.expQ) begin
      failures++;
      $display("[TB] FAIL q cyc=%0d addr=%0d actual=%h required=%h", e.cyc, e.a, q, e.expQ);
    end
`ifdef SINGLE_PORT_RAM_PARITY_EN
    checks++;
    if (parityErr !== e.expPerr) begin
      failures++;
      $display("[TB] FAIL parity_err cyc=%0d addr=%0d actual=%b required=%b",
               e.cyc, e.a, parityErr, e.expPerr);
    end
`endif
  endtask

  // Monitor: every edge with a queued expectation is compared just after the edge.
  always @(posedge clk) begin
    cycle++;
    #1;
    if (sbQ.size() > 0) begin
      cur = sbQ.pop_front();
      checkOutput(cur);
    end
  end

  initial begin
    rst  = 1'b1;
    we   = 1'b0;
    addr = '0;
    data = '0;
`ifdef SINGLE_PORT_RAM_PARITY_EN
    errInject = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      modelMem[i] = 0;
      modelInj[i] = 1'b0;
    end

    // Single-cycle reset, then the sweep with write attempts that must be ignored.
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 10)
        applyStimulus(1'b0, 1'b1, 9, 'hFF, 1'b0);
      else
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
                      int'($urandom_range(0, 255)), 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 31, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 63, 0, 1'b0);

    // Back-to-back writes then reads.
    applyStimulus(1'b0, 1'b1, 0, 'h01, 1'b0);
    applyStimulus(1'b0, 1'b1, 1, 'h02, 1'b0);
    applyStimulus(1'b0, 1'b1, 2, 'h03, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2, 0, 1'b0);

    // Write-first, the busy-time write location, top word, out-of-range write/read.
    applyStimulus(1'b0, 1'b1, 5, 'hA5, 1'b0);
    applyStimulus(1'b0, 1'b0, 9, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 63, 'h5A, 1'b0);
    applyStimulus(1'b0, 1'b1, 100, 'h77, 1'b0);
    applyStimulus(1'b0, 1'b0, 100, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 36, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 63, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5, 0, 1'b0);

    // Reset restarted at sweep pointer 20.
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, i, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < DEPTH + 4; i++) applyStimulus(1'b0, 1'b0, 5, 0, 1'b0);

`ifdef SINGLE_PORT_RAM_PARITY_EN
    applyStimulus(1'b0, 1'b1, 7, 'h3C, 1'b1);
    applyStimulus(1'b0, 1'b0, 7, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 7, 'h3C, 1'b0);
    applyStimulus(1'b0, 1'b0, 7, 0, 1'b0);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 79)), int'($urandom_range(0, 255)),
                    1'($urandom_range(0, 3) == 0));
    end

    @(posedge clk);
    #2;
    if (sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain actual=%0d required=0 pending expectations", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/single_port_ram.md
SINGLE_PORT_RAM -- requirements
Module: single_port_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 6, address width in bits.
REQ-003 Parameter DEPTH, default 64, number of words; DEPTH SHALL be <= 2**ADDR_WIDTH.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 data  input  DATA_WIDTH  write data.
REQ-007 addr  input  ADDR_WIDTH  shared read/write address.
REQ-008 we  input  1  write enable, active-high.
REQ-009 q  output  DATA_WIDTH  read data.
REQ-010 busy  output  1  high while the post-reset clear sweep runs.

Function
REQ-011 Storage SHALL be DEPTH words of DATA_WIDTH bits in one array.
REQ-012 Write: at a rising edge with we=1, busy=0, rst=0 and addr<DEPTH, mem[addr] SHALL take data.
REQ-013 Read: the address SHALL be registered every edge (addr_reg<=addr); q SHALL equal mem[addr_reg], giving one-cycle read latency.
REQ-014 Read-during-write to the same address SHALL be write-first: q shows the new data after that edge.
REQ-015 we=1 with addr>=DEPTH SHALL be ignored; addr_reg>=DEPTH SHALL drive q=0.
REQ-016 Reads SHALL be non-destructive; we=0 SHALL leave memory unchanged.
REQ-017 While busy=1, q SHALL be forced to 0 and writes SHALL be ignored.

Reset
REQ-018 At every edge with rst=1: addr_reg<=0, clear pointer<=0, busy<=1; memory is not written on that edge.
REQ-019 At each edge with rst=0 and busy=1, mem[pointer] SHALL be set to 0 and pointer SHALL increment.
REQ-020 busy SHALL fall on the edge that clears location DEPTH-1, i.e. DEPTH edges after rst deasserts.
REQ-021 rst asserted mid-sweep SHALL restart the sweep from location 0.
REQ-022 After reset completes, every location SHALL read 0 and q SHALL be 0.

Configuration
REQ-023 Macro SINGLE_PORT_RAM_PARITY_EN: when defined, each word stores one extra even-parity bit computed from data on write; the sweep stores parity 0.
REQ-024 With SINGLE_PORT_RAM_PARITY_EN defined, output parity_err (1 bit) SHALL equal the XOR of the stored parity bit and the parity of the stored word at addr_reg; it SHALL be 0 while busy=1.
REQ-025 With SINGLE_PORT_RAM_PARITY_EN defined, input err_inject (1 bit) SHALL invert the stored parity bit on a write when high.
REQ-026 Without SINGLE_PORT_RAM_PARITY_EN, parity_err, err_inject and parity storage SHALL NOT exist.

Verification
REQ-027 Pulse rst 1 cycle -> busy=1 for 64 edges then 0; reads of addr 0, 31 and 63 -> q=0x00.
REQ-028 After reset, write 0x01@0, 0x02@1, 0x03@2 on successive edges, then we=0 and read 0,1,2 -> q=0x01,0x02,0x03, each one edge after addr is applied.
REQ-029 Hold addr=5, we=1, data=0xA5 for one edge -> q=0xA5 immediately after that edge (write-first).
REQ-030 we=1, data=0xFF during busy -> after busy falls, that location reads 0x00.
REQ-031 Assert rst at sweep pointer 20 -> busy stays high for 64 edges after the new rst deasserts.
REQ-032 With SINGLE_PORT_RAM_PARITY_EN, write 0x3C@7 with err_inject=1 -> reading 7 gives q=0x3C and parity_err=1; rewrite with err_inject=0 -> parity_err=0.
